// File: rtl/program_counter.sv
// program_counter: registered instruction address with increment or bus load.
// Holds when disabled; flags a single-cycle wrap pulse on increment overflow.
module program_counter #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      INCREMENT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    input  logic             select,
    input  logic             pc_enable,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    localparam logic [WIDTH:0] INC_EXT = (WIDTH + 1)'(INCREMENT);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH:0]   inc_sum;

    // Next count: enable gates everything, then select picks load vs. step.
    always_comb begin
        out_d   = out_q;
        wrap_d  = 1'b0;
        inc_sum = {1'b0, out_q} + INC_EXT;
        if (pc_enable) begin
            if (select) begin
                out_d = bus;
            end else begin
                out_d  = inc_sum[WIDTH-1:0];
                wrap_d = inc_sum[WIDTH];
            end
        end
    end

    // Counter and wrap flag; rst low clears immediately, ignoring clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plan followed by random traffic,
// compared against an arithmetic model of the counter.
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic [15:0] bus;
    logic        select;
    logic        pc_enable;
    logic [15:0] out;
    logic        wrap;

    int checks;
    int failures;

    // reference state
    int unsigned m_pc;
    bit          m_wrap;

    program_counter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .select    (select),
        .pc_enable (pc_enable),
        .out       (out),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp_pc,
                         input logic exp_wrap);
        checks++;
        assert (out === exp_pc) else begin
            failures++;
            $error("FAIL %s out observed=%h expected=%h", tag, out, exp_pc);
        end
        checks++;
        assert (wrap === exp_wrap) else begin
            failures++;
            $error("FAIL %s wrap observed=%b expected=%b", tag, wrap, exp_wrap);
        end
    endtask

    // Model: what one clock edge does to the counter, as plain arithmetic.
    task automatic model_edge(input logic en, input logic sel,
                              input logic [15:0] b);
        int unsigned nxt;
        if (rst !== 1'b1) begin
            m_pc   = 0;
            m_wrap = 0;
        end else if (en !== 1'b1) begin
            m_wrap = 0;
        end else if (sel === 1'b1) begin
            m_pc   = b;
            m_wrap = 0;
        end else begin
            nxt    = m_pc + 1;
            m_wrap = (nxt > 65535);
            m_pc   = nxt % 65536;
        end
    endtask

    task automatic tick(input string tag, input logic en, input logic sel,
                        input logic [15:0] b);
        pc_enable = en;
        select    = sel;
        bus       = b;
        @(posedge clk);
        model_edge(en, sel, b);
        #1;
        check(tag, m_pc[15:0], m_wrap);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_pc      = 0;
        m_wrap    = 0;
        rst       = 1'b0;
        bus       = 16'h0;
        select    = 1'b0;
        pc_enable = 1'b0;

        #2;
        check("reset_initial", 16'h0000, 1'b0);
        tick("reset_hold_e1", 1'b1, 1'b0, 16'h0);
        tick("reset_hold_e2", 1'b1, 1'b0, 16'h0);

        rst = 1'b1;
        tick("inc_1", 1'b1, 1'b0, 16'h0);
        tick("inc_2", 1'b1, 1'b0, 16'h0);
        tick("inc_3", 1'b1, 1'b0, 16'h0);

        for (int i = 0; i < 4; i++)
            tick("hold", 1'b0, i[0], 16'h1234);
        tick("hold_x_inputs", 1'b0, 1'bx, 16'hxxxx);

        tick("load_3f", 1'b1, 1'b1, 16'h003F);
        tick("inc_after_load", 1'b1, 1'b0, 16'h0);

        // async reset between edges while enabled
        pc_enable = 1'b1;
        select    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        m_pc   = 0;
        m_wrap = 0;
        check("async_reset_mid", 16'h0000, 1'b0);
        #1;
        rst = 1'b1;
        tick("resume_1", 1'b1, 1'b0, 16'h0);
        tick("resume_2", 1'b1, 1'b0, 16'h0);

        tick("load_ffff", 1'b1, 1'b1, 16'hFFFF);
        tick("wrap_pulse", 1'b1, 1'b0, 16'h0);
        tick("after_wrap", 1'b1, 1'b0, 16'h0);
        tick("load_zero", 1'b1, 1'b1, 16'h0000);
        tick("load_ffff_b", 1'b1, 1'b1, 16'hFFFF);
        tick("wrap_then_hold", 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 300; i++) begin
            logic        en;
            logic        sel;
            logic [15:0] b;
            en  = ($urandom_range(0, 3) != 0);
            sel = ($urandom_range(0, 4) == 0);
            b   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                m_pc   = 0;
                m_wrap = 0;
                check("rand_async_reset", 16'h0000, 1'b0);
                rst = 1'b1;
            end
            tick("random", en, sel, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
16-bit program counter register for the CPU datapath. Each enabled clock edge either increments the count or loads a jump target from the shared data bus. It holds its value when not enabled. Its output drives instruction-memory addressing and can be gated back onto the bus by surrounding logic.

Parameters:
WIDTH, 16, bit width of the counter, bus input and output.
RESET_VALUE, 0, value loaded into the counter on reset.
INCREMENT, 1, step added on an increment cycle.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
bus  input  WIDTH  load source (jump/branch target) taken when select=1.
select  input  1  source select: 0 = increment, 1 = load from bus.
pc_enable  input  1  update enable; 0 = hold.
out  output  WIDTH  current counter value (registered).
wrap  output  1  registered one-cycle pulse: the last update was an increment that wrapped past all-ones.

Behaviour:
- Reset: rst=0 immediately, without waiting for clk, forces out=RESET_VALUE and wrap=0. The block stays in reset while rst=0, and clock edges are ignored.
- Reset release: the first rising edge with rst=1 is a normal update edge.
- Rising edge, rst=1, pc_enable=0: out holds its value and wrap=0. bus and select are don't-care.
- Rising edge, rst=1, pc_enable=1, select=0: out <= out + INCREMENT, modulo 2^WIDTH.
  - wrap=1 for exactly that cycle if the add carries out. With the defaults this is 0xFFFF -> 0x0000.
  - Otherwise wrap=0.
- Rising edge, rst=1, pc_enable=1, select=1: out <= bus, sampled at the edge, and wrap=0. A load never sets wrap, even if bus=0.
- Latency: one cycle. The new value is visible on out right after the updating edge.
- There is no combinational path from bus, select or pc_enable to out.
- Priority: reset > pc_enable > select.
- Reset mid-operation: an asynchronous assertion overrides any pending load or increment. There is no partial update.
- Inputs that are X or Z while pc_enable=0 must not disturb out.
- Width rules: unsigned arithmetic, result truncated to WIDTH bits. bus is always exactly WIDTH bits.

Test Plan:
- Reset: drive rst=0 between clock edges -> out=0x0000 and wrap=0 before the next edge. Hold rst=0 for two edges -> out stays 0x0000.
- Increment: rst=1, pc_enable=1, select=0, bus=0 for 3 edges from 0x0000 -> out=0x0001, 0x0002, 0x0003 on successive edges.
- Hold: pc_enable=0 with bus=0x1234 and select toggling, over 4 edges -> out stays at its prior value (for example 0x0003), wrap=0.
- Load: pc_enable=1, select=1, bus=0x003F -> out=0x003F after one edge. Then select=0 -> 0x0040 on the next edge.
- Wrap: load 0xFFFF, then increment -> out=0x0000 and wrap=1 for one cycle. The next increment gives out=0x0001 and wrap=0.
- Async reset mid-count: with out=0x0040 and pc_enable=1, pulse rst=0 for a fraction of a cycle -> out=0x0000 immediately. After release, increments resume from 0x0000.
